// File: rtl/float_sequence_tx.sv
// float_sequence_tx: buffers up to DEPTH IEEE-754 single words and replays
// them as one gap-free valid/last frame into the float accumulator.
// The optional build macro FLOAT_SEQ_TX_FILTER_EN makes the buffer reject
// NaN/Inf words and adds a sticky err output.
module float_sequence_tx #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic              start,
  output logic [31:0]       m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W:0]   count,
`ifdef FLOAT_SEQ_TX_FILTER_EN
  output logic              err,
`endif
  output logic              wr_drop,
  output logic              done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   rd_idx;
  logic [CNT_W-1:0]    frame_len;

  logic                start_ok_c;
  logic                can_store_c;
  logic                bad_word_c;
  logic                wr_accept_c;
  logic [CNT_W-1:0]    count_inc_c;

  // A start with an empty buffer is ignored; a valid start wins over a same-cycle write.
  assign start_ok_c  = (state == IDLE) && start && (count != '0);
  assign can_store_c = (state == IDLE) && !start_ok_c && (count != CNT_W'(DEPTH));
  assign count_inc_c = count + CNT_W'(1);

`ifdef FLOAT_SEQ_TX_FILTER_EN
  // Exponent all-ones marks NaN or +/-Inf, which would poison the running sum.
  assign bad_word_c = (wr_data[30:23] == 8'hFF);
`else
  assign bad_word_c = 1'b0;
`endif

  assign wr_accept_c = wr_en && can_store_c && !bad_word_c;

  // Buffer storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept_c) begin
      mem[count[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Control FSM with registered stream and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      rd_idx    <= '0;
      frame_len <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      full      <= 1'b0;
      wr_drop   <= 1'b0;
      done      <= 1'b0;
`ifdef FLOAT_SEQ_TX_FILTER_EN
      err       <= 1'b0;
`endif
    end else begin
      wr_drop <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          m_data  <= '0;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          busy    <= 1'b0;
          if (wr_accept_c) begin
            count <= count_inc_c;
            full  <= (count_inc_c == CNT_W'(DEPTH));
          end else if (wr_en) begin
            wr_drop <= 1'b1;
`ifdef FLOAT_SEQ_TX_FILTER_EN
            if (can_store_c && bad_word_c) begin
              err <= 1'b1;
            end
`endif
          end
          if (start_ok_c) begin
            state     <= SEND;
            rd_idx    <= '0;
            frame_len <= count;
          end
        end
        SEND: begin
          if (wr_en) begin
            wr_drop <= 1'b1;
          end
          if (m_last) begin
            // Frame finished last cycle: drop the stream and consume the buffer.
            state   <= IDLE;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            count   <= '0;
            full    <= 1'b0;
          end else begin
            m_data  <= mem[rd_idx];
            m_valid <= 1'b1;
            m_last  <= ({1'b0, rd_idx} == (frame_len - CNT_W'(1)));
            busy    <= 1'b1;
            rd_idx  <= rd_idx + ADDR_W'(1);
          end
        end
      endcase
    end
  end

endmodule
